sad_pixel_feeder: RTL and testbench
===================================

Name: sad_pixel_feeder

Overview:
- Producer side of the SAD engine's pixel interface.
- On start, walks one 16x16 current block and the matching 16x16 candidate region of the search-window memory, then prefetches byte pairs into a small internal FIFO.
- Each data_load pulse from the SAD engine updates A and B with the next pair.
- Sits between the current-block/search-window RAMs and the SAD engine. A full-search sequencer drives one candidate per start.

Parameters:
BLK_W, 16, block edge in pixels; block is BLK_W*BLK_W = 256 pixels.
WIN_W, 48, search-window width and height in pixels.
FIFO_DEPTH, 4, internal pair-FIFO entries (power of two, >=2).

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse, begin a block; ignored unless IDLE
cand_x  in  6  candidate column offset in window, captured on start
cand_y  in  6  candidate row offset in window, captured on start
cur_addr  out  8  current-block RAM address (row*16+col)
cur_rd  out  1  current-block RAM read strobe
cur_data  in  8  current-block RAM data, valid 1 cycle after cur_rd
ref_addr  out  12  window RAM address ((cand_y+row)*WIN_W + cand_x + col)
ref_rd  out  1  window RAM read strobe (always equal to cur_rd)
ref_data  in  8  window RAM data, valid 1 cycle after ref_rd
data_load  in  1  pop request from SAD engine
A  out  8  current-block pixel of the presented pair
B  out  8  candidate pixel of the presented pair
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the 256th pop
underflow  out  1  sticky error: pop requested while FIFO empty and pairs remain

Behaviour:
- Reset (rst=0, async): state IDLE; all counters, FIFO pointers and count = 0; A = 0, B = 0; cur_rd = ref_rd = 0; addresses = 0; busy = 0, done = 0, underflow = 0.
- FSM states:
  - IDLE: start=1 -> FETCH. Captures cand_x/cand_y, clamped to WIN_W-BLK_W = 32 when larger. Clears issue_cnt, pop_cnt and underflow. Sets busy.
  - FETCH: read issues while issue_cnt < 256; then -> DRAIN.
  - DRAIN: no issues; waits for pop_cnt == 256 -> DONE.
  - DONE: done = 1 for exactly one cycle -> IDLE; busy drops the same edge.
- Issue rule:
  - cur_rd = ref_rd = 1 in a cycle iff state is FETCH and (fifo_count + inflight) < FIFO_DEPTH.
  - inflight is 0 or 1 (read latency 1).
  - Read data is written into the FIFO the cycle after the strobe.
  - issue_cnt (9 bits) increments per issue.
  - Issue order is raster: col = issue_cnt[3:0], row = issue_cnt[7:4].
- Pop rule:
  - data_load=1 with FIFO non-empty and pop_cnt < 256: A/B take the FIFO head at that clock edge (visible next cycle), pop_cnt increments, and the head is removed.
  - A/B hold their value until the next successful pop.
  - Simultaneous write and pop in one cycle is legal; fifo_count is unchanged.
- Boundaries:
  - data_load with FIFO empty and pop_cnt < 256: no pop, A/B hold, underflow set (sticky until next start or reset).
  - data_load when pop_cnt == 256, or in IDLE/DONE: ignored, no error. The engine issues one extra data_load per block at its loop-exit check.
  - FIFO full: no issue is made, so no overflow is possible by construction.
  - start while busy: ignored.
  - Reset mid-block: everything aborts immediately to reset values; the next start begins a fresh block.
- Arithmetic:
  - ref_addr = (cand_y + row) * 48 + cand_x + col, computed in 12 bits. Max value is 47*48+47 = 2303, so no wrap.
  - With the RAMs always returning data, the minimum latency start -> first pair is 2 cycles (cur_rd at cycle 1 after start, FIFO write at cycle 2).

Test Plan:
- Reset values: hold rst=0 with data_load toggling -> A=B=0, busy=0, done=0, underflow=0, no rd strobes.
- Basic block: RAMs return cur_data = addr[7:0] and ref_data = addr[7:0]^8'hFF; start with cand=(0,0); SAD-engine model pops every other cycle -> 256 pairs arrive in raster order with pair k: A=k, B=~k[7:0]. done pulses once after the 256th pop. The 257th data_load is ignored and underflow stays 0.
- Address check: cand_x=5, cand_y=3 -> first ref_addr=149, pair 16 ref_addr=197, last ref_addr=(18*48)+20=884.
- Clamp: cand_x=40, cand_y=63 -> both clamped to 32; first ref_addr=32*48+32=1568.
- Underflow and back-pressure: pop on the cycle right after start -> underflow=1, A/B unchanged. Then no pops for 20 cycles -> exactly FIFO_DEPTH (4) issues, rd strobes stop. Resume popping every cycle -> stream completes correctly.
- Reset mid-block: assert rst after 100 pops -> immediate return to reset values. New start with cand=(1,1) -> first pair B from ref_addr 49.

Source files
------------

// File: rtl/sad_pixel_feeder.sv
// Pixel-pair producer for the SAD engine: fetches a current block and one candidate region
// from their RAMs into a small pair FIFO and presents one pair per data_load pop.
`timescale 1ns/1ps
module sad_pixel_feeder #(
   parameter int unsigned BLK_W      = 16,
   parameter int unsigned WIN_W      = 48,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [5:0]  cand_x,
   input  logic [5:0]  cand_y,
   output logic [7:0]  cur_addr,
   output logic        cur_rd,
   input  logic [7:0]  cur_data,
   output logic [11:0] ref_addr,
   output logic        ref_rd,
   input  logic [7:0]  ref_data,
   input  logic        data_load,
   output logic [7:0]  A,
   output logic [7:0]  B,
   output logic        busy,
   output logic        done,
   output logic        underflow
);

   localparam int unsigned BW    = $clog2(BLK_W);
   localparam int unsigned NPIX  = BLK_W * BLK_W;
   localparam int unsigned CW    = 2 * BW + 1;
   localparam int unsigned PW    = $clog2(FIFO_DEPTH);
   localparam logic [5:0]  CLAMP = 6'(WIN_W - BLK_W);

   typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_t;

   state_t          r_state, w_state_next;
   logic [5:0]      r_cx, r_cy;
   logic [CW-1:0]   r_issue_cnt, r_pop_cnt;
   logic            r_inflight;
   logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
   logic [PW:0]     r_count;
   logic [7:0]      r_a, r_b;
   logic            r_underflow;
   logic [7:0]      r_fifo_a [FIFO_DEPTH];
   logic [7:0]      r_fifo_b [FIFO_DEPTH];

   logic            w_start, w_active, w_pops_left, w_empty;
   logic            w_issue, w_pop, w_uf;
   logic [PW+1:0]   w_occ;
   logic [11:0]     w_row, w_col;

   assign w_start     = start && (r_state == StIdle);
   assign w_active    = (r_state == StFetch) || (r_state == StDrain);
   assign w_pops_left = r_pop_cnt < CW'(NPIX);
   assign w_empty     = (r_count == '0);
   // Reserve a slot for the read still in flight so the FIFO can never overflow.
   assign w_occ       = (PW+2)'(r_count) + (PW+2)'(r_inflight);
   assign w_issue     = (r_state == StFetch) && (r_issue_cnt < CW'(NPIX))
                        && (w_occ < (PW+2)'(FIFO_DEPTH));
   assign w_pop       = data_load && w_active && w_pops_left && !w_empty;
   assign w_uf        = data_load && w_active && w_pops_left && w_empty;

   assign w_col = 12'(r_issue_cnt[BW-1:0]);
   assign w_row = 12'(r_issue_cnt[2*BW-1:BW]);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= StIdle;
      else      r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (start) w_state_next = StFetch;
         StFetch: if (r_issue_cnt == CW'(NPIX)) w_state_next = StDrain;
         StDrain: if (r_pop_cnt == CW'(NPIX)) w_state_next = StDone;
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      busy      = (r_state != StIdle);
      done      = (r_state == StDone);
      cur_rd    = w_issue;
      ref_rd    = w_issue;
      cur_addr  = 8'(r_issue_cnt[2*BW-1:0]);
      ref_addr  = (12'(r_cy) + w_row) * 12'(WIN_W) + 12'(r_cx) + w_col;
      A         = r_a;
      B         = r_b;
      underflow = r_underflow;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cx        <= '0;
         r_cy        <= '0;
         r_issue_cnt <= '0;
         r_pop_cnt   <= '0;
         r_inflight  <= 1'b0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_underflow <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_start) begin
            r_cx        <= (cand_x > CLAMP) ? CLAMP : cand_x;
            r_cy        <= (cand_y > CLAMP) ? CLAMP : cand_y;
            r_issue_cnt <= '0;
            r_pop_cnt   <= '0;
            r_underflow <= 1'b0;
         end
         if (w_issue) r_issue_cnt <= r_issue_cnt + CW'(1);
         if (r_inflight) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop) begin
            r_rd_ptr  <= r_rd_ptr + PW'(1);
            r_pop_cnt <= r_pop_cnt + CW'(1);
            r_a       <= r_fifo_a[r_rd_ptr];
            r_b       <= r_fifo_b[r_rd_ptr];
         end
         if (w_uf) r_underflow <= 1'b1;
         r_count <= r_count + (PW+1)'(r_inflight) - (PW+1)'(w_pop);
      end
   end

   // Read data lands one cycle after its strobe, tracked by r_inflight.
   always_ff @(posedge clk) begin
      if (r_inflight) begin
         r_fifo_a[r_wr_ptr] <= cur_data;
         r_fifo_b[r_wr_ptr] <= ref_data;
      end
   end

endmodule

// File: tb/tb_sad_pixel_feeder.sv
// Directed bench for sad_pixel_feeder: RAM models return address-derived data so every
// presented pair and every fetch address can be predicted from the candidate position.
`timescale 1ns/1ps
module tb_sad_pixel_feeder;

   logic        clk = 1'b0, rst = 1'b0, start = 1'b0, data_load = 1'b0;
   logic [5:0]  cand_x = '0, cand_y = '0;
   logic [7:0]  cur_addr, cur_data = '0, A, B;
   logic [11:0] ref_addr;
   logic [7:0]  ref_data = '0;
   logic        cur_rd, ref_rd, busy, done, underflow;

   int          n_vec = 0, n_miss = 0;
   int          log_ref[$];
   int          log_cur[$];
   logic [7:0]  exp_a = '0, exp_b = '0;

   always #5 clk = ~clk;

   sad_pixel_feeder dut (
      .clk(clk), .rst(rst), .start(start), .cand_x(cand_x), .cand_y(cand_y),
      .cur_addr(cur_addr), .cur_rd(cur_rd), .cur_data(cur_data),
      .ref_addr(ref_addr), .ref_rd(ref_rd), .ref_data(ref_data),
      .data_load(data_load), .A(A), .B(B), .busy(busy), .done(done), .underflow(underflow)
   );

   always @(posedge clk) begin
      if (cur_rd) cur_data <= cur_addr;
      if (ref_rd) ref_data <= ref_addr[7:0] ^ 8'hFF;
   end

   always @(negedge clk) begin
      if (cur_rd) begin
         log_ref.push_back(int'(ref_addr));
         log_cur.push_back(int'(cur_addr));
      end
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation exceeded time limit, required finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int ref_of(input int cx, input int cy, input int k);
      return (cy + k / 16) * 48 + cx + k % 16;
   endfunction

   function automatic int log_at(input int idx);
      return (idx < log_ref.size()) ? log_ref[idx] : -1;
   endfunction

   task automatic do_start(input int x, input int y);
      start = 1'b1; cand_x = 6'(x); cand_y = 6'(y);
      tick();
      start = 1'b0;
      n_vec++;
      if (busy !== 1'b1) begin
         n_miss++; $display("FAIL start_busy: busy=%b required 1", busy);
      end
   endtask

   task automatic stream(input int cx, input int cy, input int gap, input int npops,
                         input logic exp_uf);
      for (int k = 0; k < npops; k++) begin
         data_load = 1'b1;
         tick();
         data_load = 1'b0;
         exp_a = 8'(k);
         exp_b = 8'(ref_of(cx, cy, k)) ^ 8'hFF;
         n_vec++;
         if (A !== exp_a || B !== exp_b || ref_rd !== cur_rd) begin
            n_miss++;
            $display("FAIL pair_%0d: A=%0d B=%0d rd=%b/%b, required A=%0d B=%0d equal rd",
                     k, A, B, cur_rd, ref_rd, exp_a, exp_b);
         end
         if (k < npops - 1) repeat (gap) tick();
      end
      if (npops == 256) begin
         n_vec++;
         if (done !== 1'b0 || busy !== 1'b1) begin
            n_miss++; $display("FAIL pre_done: done=%b busy=%b required 0 1", done, busy);
         end
         data_load = 1'b1;  // the engine's extra loop-exit load
         tick();
         data_load = 1'b0;
         n_vec++;
         if (done !== 1'b1 || A !== exp_a || B !== exp_b || underflow !== exp_uf) begin
            n_miss++;
            $display("FAIL done_pulse: done=%b A=%0d B=%0d uf=%b, required 1 %0d %0d %b",
                     done, A, B, underflow, exp_a, exp_b, exp_uf);
         end
         tick();
         n_vec++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            n_miss++; $display("FAIL done_end: done=%b busy=%b required 0 0", done, busy);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         data_load = i[0];
         tick();
         n_vec++;
         if ({A, B, busy, done, underflow, cur_rd, ref_rd} !== 21'd0) begin
            n_miss++;
            $display("FAIL reset_%0d: A=%0d B=%0d busy=%b done=%b uf=%b rd=%b, required all 0",
                     i, A, B, busy, done, underflow, cur_rd);
         end
      end
      data_load = 1'b0;
      rst = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int base = log_ref.size();
      int bad = -1;
      do_start(0, 0);
      tick(); tick();
      stream(0, 0, 1, 256, 1'b0);
      n_vec++;
      if (log_ref.size() - base != 256) begin
         n_miss++; $display("FAIL issue_count: %0d issues, required 256", log_ref.size() - base);
      end
      for (int k = 0; k < 256 && base + k < log_ref.size(); k++)
         if (bad < 0 && (log_cur[base + k] != k || log_ref[base + k] != ref_of(0, 0, k))) bad = k;
      n_vec++;
      if (bad >= 0) begin
         n_miss++; $display("FAIL raster_order: first wrong issue %0d, required none", bad);
      end
   endtask

   task automatic test_addr();
      int base = log_ref.size();
      do_start(5, 3);
      tick(); tick();
      stream(5, 3, 1, 256, 1'b0);
      n_vec++;
      if (log_at(base) != 149 || log_at(base + 16) != 197 || log_at(base + 255) != 884) begin
         n_miss++;
         $display("FAIL addr_5_3: got %0d %0d %0d, required 149 197 884",
                  log_at(base), log_at(base + 16), log_at(base + 255));
      end
   endtask

   task automatic test_clamp();
      int base = log_ref.size();
      do_start(40, 63);
      tick(); tick();
      stream(32, 32, 0, 256, 1'b0);
      n_vec++;
      if (log_at(base) != 1568) begin
         n_miss++; $display("FAIL clamp_addr: got %0d, required 1568", log_at(base));
      end
   endtask

   task automatic test_underflow();
      int base = log_ref.size();
      logic [7:0] hold_a = exp_a, hold_b = exp_b;
      start = 1'b1; cand_x = 6'd0; cand_y = 6'd0;
      tick();
      start = 1'b0;
      data_load = 1'b1;
      tick();
      data_load = 1'b0;
      n_vec++;
      if (underflow !== 1'b1 || A !== hold_a || B !== hold_b) begin
         n_miss++;
         $display("FAIL underflow: uf=%b A=%0d B=%0d, required 1 %0d %0d",
                  underflow, A, B, hold_a, hold_b);
      end
      start = 1'b1; cand_x = 6'd10; cand_y = 6'd10;  // must be ignored while busy
      tick();
      start = 1'b0;
      repeat (19) tick();
      n_vec++;
      if (log_ref.size() - base != 4 || cur_rd !== 1'b0) begin
         n_miss++;
         $display("FAIL backpressure: %0d issues rd=%b, required 4 0",
                  log_ref.size() - base, cur_rd);
      end
      stream(0, 0, 0, 256, 1'b1);
   endtask

   task automatic test_reset_mid();
      int base;
      do_start(0, 0);
      tick(); tick();
      stream(0, 0, 0, 100, 1'b0);
      #2 rst = 1'b0;
      #1;
      n_vec++;
      if ({A, B, busy, done, underflow, cur_rd, ref_rd, cur_addr, ref_addr} !== 41'd0) begin
         n_miss++;
         $display("FAIL reset_mid: A=%0d B=%0d busy=%b rd=%b caddr=%0d raddr=%0d, required 0",
                  A, B, busy, cur_rd, cur_addr, ref_addr);
      end
      #2 rst = 1'b1;
      tick();
      base = log_ref.size();
      do_start(1, 1);
      tick(); tick();
      stream(1, 1, 1, 256, 1'b0);
      n_vec++;
      if (log_at(base) != 49) begin
         n_miss++; $display("FAIL restart_addr: got %0d, required 49", log_at(base));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_addr();
      test_clamp();
      test_underflow();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
